// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding, control bundle,
// register-index width and the NOP the IF/ID register loads on a flush.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned FL_CNT_W   = 3;
  localparam int unsigned WAIT_CNT_W = 16;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN      = 6'b110101;
  localparam hz_ctrl_t CTRL_FREEZE   = 6'b000000;
  localparam hz_ctrl_t CTRL_SQUASH   = 6'b111111;
  localparam hz_ctrl_t CTRL_LOAD_USE = 6'b000111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EXE/MEM observations in, stage-register controls and
// performance counters out.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_memread;
  logic                 ex_redirect;
  logic                 mem_req;
  logic                 mem_ack;

  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_en;
  logic                 idex_bubble;
  logic                 exmem_en;
  logic                 mem_err;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_req, mem_ack,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_redirect, mem_req, mem_ack,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
           mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hz_perf_counter.sv
// Wrapping event counter with synchronous active-low clear and increment enable.
module hz_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EXE and EXE/MEM registers of the 5-stage pipeline:
// load-use bubbles, wrong-path squash on redirect, and full freeze while data memory is busy.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 32
) (
  input logic                   clk,
  input logic                   nrst,
  pipeline_hazard_ctrl_if.slave bus
);

  hz_state_e             state_q, state_d;
  hz_state_e             ret_q, ret_d;
  hz_state_e             act_state;
  logic [FL_CNT_W-1:0]   fl_q, fl_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  err_q, err_d;
  hz_ctrl_t              ctrl, ctrl_g;
  logic                  act;
  logic                  load_use;
  logic                  mem_stall;
  logic                  stall_eff;
  logic                  flush_inc;

  assign load_use = bus.ex_memread && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
  assign mem_stall = bus.mem_req && !bus.mem_ack;

  // The ack cycle of MEM_WAIT is decided exactly as the return state would decide it,
  // with the memory stall masked; act_state selects which state's rules apply.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    ret_d     = ret_q;
    fl_d      = fl_q;
    wait_d    = wait_q;
    err_d     = err_q;
    flush_inc = 1'b0;
    act       = 1'b1;
    act_state = state_q;
    stall_eff = mem_stall;

    if (state_q == ST_MEM_WAIT) begin
      stall_eff = 1'b0;
      if (wait_q != '1) wait_d = wait_q + WAIT_CNT_W'(1);
      if (wait_q == WAIT_CNT_W'(MEM_TIMEOUT)) err_d = 1'b1;
      if (bus.mem_ack) begin
        act_state = ret_q;
      end else begin
        act  = 1'b0;
        ctrl = CTRL_FREEZE;
      end
    end

    if (act) begin
      case (act_state)
        ST_FLUSH: begin
          if (stall_eff) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_MEM_WAIT;
            ret_d   = ST_FLUSH;
            wait_d  = WAIT_CNT_W'(1);
          end else begin
            ctrl = CTRL_SQUASH;
            if (bus.ex_redirect) begin
              flush_inc = 1'b1;
              fl_d      = FL_CNT_W'(FLUSH_CYCLES - 1);
              state_d   = ST_FLUSH;
            end else if (fl_q <= FL_CNT_W'(1)) begin
              fl_d    = '0;
              state_d = ST_RUN;
            end else begin
              fl_d    = fl_q - FL_CNT_W'(1);
              state_d = ST_FLUSH;
            end
          end
        end
        default: begin
          state_d = ST_RUN;
          if (stall_eff) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_MEM_WAIT;
            ret_d   = ST_RUN;
            wait_d  = WAIT_CNT_W'(1);
          end else if (bus.ex_redirect) begin
            ctrl      = CTRL_SQUASH;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              fl_d    = FL_CNT_W'(FLUSH_CYCLES - 1);
              state_d = ST_FLUSH;
            end
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      fl_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fl_q    <= fl_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_g = nrst ? ctrl : CTRL_FREEZE;

  assign bus.pc_en       = ctrl_g.pc_en;
  assign bus.ifid_en     = ctrl_g.ifid_en;
  assign bus.ifid_flush  = ctrl_g.ifid_flush;
  assign bus.idex_en     = ctrl_g.idex_en;
  assign bus.idex_bubble = ctrl_g.idex_bubble;
  assign bus.exmem_en    = ctrl_g.exmem_en;
  assign bus.mem_err     = err_q;

  hz_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc_i (nrst && !ctrl_g.pc_en),
    .cnt_o (bus.stall_cnt)
  );

  hz_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc_i (nrst && flush_inc),
    .cnt_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed per-cycle expectations, a negedge
// monitor pops and compares them against the controller outputs.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] E_RUN = 6'b110101;  // {pc,ifid,flush,idex,bubble,exmem}
  localparam logic [5:0] E_FRZ = 6'b000000;
  localparam logic [5:0] E_SQ  = 6'b111111;
  localparam logic [5:0] E_LU  = 6'b000111;

  typedef struct {
    int         tag;
    logic [5:0] en;
    logic       err;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  logic clk;
  logic nrst;
  int   total;
  int   bad;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.CNT_W(8)) bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] en_act;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      en_act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble, bus.exmem_en};
      total++;
      if (en_act !== e.en) begin
        bad++;
        $display("FAIL ctrl[%0d]: got %b want %b", e.tag, en_act, e.en);
      end
      total++;
      if (bus.mem_err !== e.err) begin
        bad++;
        $display("FAIL mem_err[%0d]: got %b want %b", e.tag, bus.mem_err, e.err);
      end
      total++;
      if (bus.stall_cnt !== e.sc) begin
        bad++;
        $display("FAIL stall_cnt[%0d]: got %0d want %0d", e.tag, bus.stall_cnt, e.sc);
      end
      total++;
      if (bus.flush_cnt !== e.fc) begin
        bad++;
        $display("FAIL flush_cnt[%0d]: got %0d want %0d", e.tag, bus.flush_cnt, e.fc);
      end
    end
  end

  task automatic drive(input logic rd_ld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic redir, input logic req, input logic ack);
    bus.ex_memread  = rd_ld;
    bus.ex_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_use_rs1  = u1;
    bus.id_rs2      = rs2;
    bus.id_use_rs2  = u2;
    bus.ex_redirect = redir;
    bus.mem_req     = req;
    bus.mem_ack     = ack;
  endtask

  task automatic apply(input int tag, input logic [5:0] en, input logic err,
                       input logic [7:0] sc, input logic [7:0] fc);
    exp_t e;
    e.tag = tag; e.en = en; e.err = err; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    nrst  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    apply(0, E_FRZ, 0, 0, 0);                    // held in reset: gated outputs

    nrst = 1'b1;
    drive(1, 5, 5, 1, 0, 0, 0, 0, 0);  apply(10, E_LU,  0, 0, 0);   // load-use on rs1
    drive(0, 5, 5, 1, 0, 0, 0, 0, 0);  apply(11, E_RUN, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0);  apply(20, E_RUN, 0, 1, 0);   // rd = x0
    drive(1, 7, 3, 1, 7, 0, 0, 0, 0);  apply(21, E_RUN, 0, 1, 0);   // rs2 match, unused
    drive(1, 7, 3, 1, 7, 1, 0, 0, 0);  apply(22, E_LU,  0, 1, 0);   // rs2 match, used
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(23, E_RUN, 0, 2, 0);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  apply(30, E_SQ,  0, 2, 0);   // redirect
    drive(1, 5, 5, 1, 0, 0, 0, 0, 0);  apply(31, E_SQ,  0, 2, 1);   // FLUSH ignores load-use
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(32, E_RUN, 0, 2, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  apply(40, E_FRZ, 0, 2, 1);   // mem stall
    apply(41, E_FRZ, 0, 3, 1);
    apply(42, E_FRZ, 0, 4, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);  apply(43, E_SQ,  0, 5, 1);   // ack + redirect
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(44, E_SQ,  0, 5, 2);
    apply(45, E_RUN, 0, 5, 2);

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);  apply(60, E_SQ,  0, 5, 2);   // enter FLUSH
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  apply(61, E_FRZ, 0, 5, 3);   // stall inside FLUSH
    apply(62, E_FRZ, 0, 6, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);  apply(63, E_SQ,  0, 7, 3);   // FLUSH resumes
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(64, E_RUN, 0, 7, 3);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);  apply(50, E_FRZ, 0, 7, 3);   // timeout
    apply(51, E_FRZ, 0, 8, 3);
    apply(52, E_FRZ, 0, 9, 3);
    apply(53, E_FRZ, 0, 10, 3);
    apply(54, E_FRZ, 0, 11, 3);
    apply(55, E_FRZ, 1, 12, 3);
    apply(56, E_FRZ, 1, 13, 3);
    nrst = 1'b0;                       apply(57, E_FRZ, 1, 14, 3);
    nrst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(58, E_RUN, 0, 0, 0);
    drive(1, 9, 9, 1, 0, 0, 0, 0, 0);  apply(59, E_LU,  0, 0, 0);   // RUN after reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  apply(65, E_RUN, 0, 1, 0);

    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
